// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative signed multiply / restoring divide sequencer.
// Operands are converted to magnitudes on start, one shift-add or
// trial-subtract step runs per clock over a shared {acc, lo} shift
// register, and sign correction is applied in FIX when HI/LO are written.
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   start     operation request, sampled only in IDLE
//   op        0 = MULT, 1 = DIV (sampled with start)
//   A, B      signed operands (sampled with start)
//   busy      operation in progress
//   done      one-cycle completion pulse
//   div_zero  last accepted DIV had B == 0
//   HI, LO    MULT: product high/low; DIV: remainder/quotient
//
// state  | meaning
// IDLE   | waiting for start
// MULT   | shift-add iteration, WIDTH edges
// DIV    | restoring-divide iteration, WIDTH edges
// FIX    | sign correction, write HI/LO, pulse done
module muldiv_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MULT = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_FIX  = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             op_q, op_d;
   logic             neg_q, neg_d;
   logic             sa_q, sa_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH:0]   acc_q, acc_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] hi_out_q, hi_out_d;
   logic [WIDTH-1:0] lo_out_q, lo_out_d;
   logic             done_q, done_d;
   logic             div_zero_q, div_zero_d;

   // Magnitudes; the most-negative value maps to unsigned 2^(WIDTH-1).
   logic [WIDTH-1:0] abs_a, abs_b;
   assign abs_a = A[WIDTH-1] ? (~A + WIDTH'(1)) : A;
   assign abs_b = B[WIDTH-1] ? (~B + WIDTH'(1)) : B;

   // Multiply step: conditional add into the upper half, then shift right.
   logic [WIDTH:0] mul_sum;
   assign mul_sum = {1'b0, acc_q[WIDTH-1:0]} + (lo_q[0] ? {1'b0, opnd_q} : '0);

   // Divide step: shift dividend MSB into the remainder, trial subtract.
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH+1:0] trial;
   assign rem_sh = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
   assign trial  = {1'b0, rem_sh} - {2'b00, opnd_q};

   logic [2*WIDTH-1:0] prod, prod_neg;
   assign prod     = {acc_q[WIDTH-1:0], lo_q};
   assign prod_neg = ~prod + (2*WIDTH)'(1);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      neg_d      = neg_q;
      sa_d       = sa_q;
      zero_d     = zero_q;
      opnd_d     = opnd_q;
      acc_d      = acc_q;
      lo_d       = lo_q;
      hi_out_d   = hi_out_q;
      lo_out_d   = lo_out_q;
      done_d     = 1'b0;
      div_zero_d = div_zero_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d       = op;
               neg_d      = A[WIDTH-1] ^ B[WIDTH-1];
               sa_d       = A[WIDTH-1];
               zero_d     = op && (B == '0);
               opnd_d     = op ? abs_b : abs_a;
               lo_d       = op ? abs_a : abs_b;
               acc_d      = '0;
               cnt_d      = '0;
               div_zero_d = 1'b0;
               if (op && (B == '0)) state_d = S_FIX;
               else if (op)         state_d = S_DIV;
               else                 state_d = S_MULT;
            end
         end
         S_MULT: begin
            acc_d = {1'b0, mul_sum[WIDTH:1]};
            lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
         end
         S_DIV: begin
            if (trial[WIDTH+1]) begin
               acc_d = rem_sh;
               lo_d  = {lo_q[WIDTH-2:0], 1'b0};
            end else begin
               acc_d = trial[WIDTH:0];
               lo_d  = {lo_q[WIDTH-2:0], 1'b1};
            end
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
         end
         default: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
            if (zero_q) begin
               div_zero_d = 1'b1;
            end else if (op_q) begin
               lo_out_d = neg_q ? (~lo_q + WIDTH'(1)) : lo_q;
               hi_out_d = sa_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
            end else begin
               hi_out_d = neg_q ? prod_neg[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
               lo_out_d = neg_q ? prod_neg[WIDTH-1:0] : prod[WIDTH-1:0];
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         op_q       <= 1'b0;
         neg_q      <= 1'b0;
         sa_q       <= 1'b0;
         zero_q     <= 1'b0;
         opnd_q     <= '0;
         acc_q      <= '0;
         lo_q       <= '0;
         hi_out_q   <= '0;
         lo_out_q   <= '0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         neg_q      <= neg_d;
         sa_q       <= sa_d;
         zero_q     <= zero_d;
         opnd_q     <= opnd_d;
         acc_q      <= acc_d;
         lo_q       <= lo_d;
         hi_out_q   <= hi_out_d;
         lo_out_q   <= lo_out_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign div_zero = div_zero_q;
   assign HI       = hi_out_q;
   assign LO       = lo_out_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;

   logic        clk;
   logic        reset;
   logic        start;
   logic        op;
   logic [31:0] A;
   logic [31:0] B;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] HI;
   logic [31:0] LO;

   int total  = 0;
   int passed = 0;

   muldiv_ctrl #(.WIDTH(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op),
      .A        (A),
      .B        (B),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .HI       (HI),
      .LO       (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Issues one operation and waits (bounded) for done. inj > 0 pulses a
   // conflicting start at that iteration. Returns with time just after the
   // done edge; lat = edges from start edge to done, bcnt = busy samples.
   task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                         input int inj, output int lat, output int bcnt);
      @(negedge clk);
      start = 1'b1; op = o; A = a; B = b;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("div_zero_clear_on_start", {31'b0, div_zero}, 32'd0);
      bcnt = busy ? 1 : 0;
      lat  = 0;
      while (!done && lat < 100) begin
         @(posedge clk);
         lat++;
         #1;
         if (busy) bcnt++;
         if (lat == inj) begin
            start = 1'b1; op = ~o; A = 32'd100; B = 32'd7;
         end else if (lat == inj + 1) begin
            start = 1'b0;
         end
      end
      start = 1'b0;
   endtask

   int lat, bcnt, done_seen;
   logic [31:0] hi_prev, lo_prev;

   initial begin
      vecs[0]  = '{1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[2]  = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[3]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[4]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
      vecs[6]  = '{1'b0, 32'h0000FFFF, 32'h0000FFFF, 32'h00000000, 32'hFFFE0001};
      vecs[7]  = '{1'b1, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFF2};
      vecs[8]  = '{1'b1, 32'h00000003, 32'h00000005, 32'h00000003, 32'h00000000};
      vecs[9]  = '{1'b0, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
      vecs[10] = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
      vecs[11] = '{1'b0, 32'h7FFFFFFF, 32'h00000002, 32'h00000000, 32'hFFFFFFFE};

      reset = 1'b0; start = 1'b0; op = 1'b0; A = '0; B = '0;
      #12;
      chk("rst_busy",     {31'b0, busy},     32'd0);
      chk("rst_done",     {31'b0, done},     32'd0);
      chk("rst_div_zero", {31'b0, div_zero}, 32'd0);
      chk("rst_hi",       HI,                32'd0);
      chk("rst_lo",       LO,                32'd0);
      @(negedge clk);
      reset = 1'b1;

      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, lat, bcnt);
         chk($sformatf("v%0d_latency", i), 32'(lat),  32'd33);
         chk($sformatf("v%0d_busy",    i), 32'(bcnt), 32'd33);
         chk($sformatf("v%0d_hi",      i), HI, vecs[i].hi);
         chk($sformatf("v%0d_lo",      i), LO, vecs[i].lo);
         chk($sformatf("v%0d_dz",      i), {31'b0, div_zero}, 32'd0);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_done_one_cycle", i), {31'b0, done}, 32'd0);
         chk($sformatf("v%0d_hi_hold", i), HI, vecs[i].hi);
      end

      // Divide by zero: one-edge latency, HI/LO untouched, flag sticky.
      hi_prev = HI; lo_prev = LO;
      run_op(1'b1, 32'd5, 32'd0, 0, lat, bcnt);
      chk("dz_latency", 32'(lat), 32'd1);
      chk("dz_flag",    {31'b0, div_zero}, 32'd1);
      chk("dz_busy",    {31'b0, busy}, 32'd0);
      chk("dz_hi",      HI, hi_prev);
      chk("dz_lo",      LO, lo_prev);
      repeat (3) @(posedge clk);
      #1;
      chk("dz_flag_hold", {31'b0, div_zero}, 32'd1);
      chk("dz_done_low",  {31'b0, done}, 32'd0);

      // Conflicting start at iteration 5 must be ignored (run_op also checks
      // that this start clears div_zero).
      run_op(1'b0, 32'd7, 32'hFFFFFFFD, 5, lat, bcnt);
      chk("ign_latency", 32'(lat), 32'd33);
      chk("ign_hi", HI, 32'hFFFFFFFF);
      chk("ign_lo", LO, 32'hFFFFFFEB);

      // Back-to-back: next start issued during the done cycle.
      run_op(1'b1, 32'd100, 32'd7, 0, lat, bcnt);
      chk("b2b_first_lo", LO, 32'd14);
      run_op(1'b0, 32'hFFFFFFFE, 32'd3, 0, lat, bcnt);
      chk("b2b_second_latency", 32'(lat), 32'd33);
      chk("b2b_second_hi", HI, 32'hFFFFFFFF);
      chk("b2b_second_lo", LO, 32'hFFFFFFFA);

      // Asynchronous reset during iteration 10 of a MULT.
      @(negedge clk);
      start = 1'b1; op = 1'b0; A = 32'd9; B = 32'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      chk("mid_rst_done", {31'b0, done}, 32'd0);
      chk("mid_rst_hi",   HI, 32'd0);
      chk("mid_rst_lo",   LO, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      done_seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done) done_seen++;
      end
      chk("mid_rst_no_done", 32'(done_seen), 32'd0);
      run_op(1'b1, 32'd100, 32'd7, 0, lat, bcnt);
      chk("post_rst_latency", 32'(lat), 32'd33);
      chk("post_rst_lo", LO, 32'd14);
      chk("post_rst_hi", HI, 32'd2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
